// File: rtl/gray_pkg.sv
// gray_pkg: shared types and constants for the Gray-code position tracker.
//   - gray_state_e : tracker FSM states
//   - DEF_WIDTH / DEF_STABLE_CYCLES : default parameter values
//   - ERR_CNT_W / POS_W / RUN_W : widths of the error counter, position
//     accumulator and stability run counter
//   - popcount() : set-bit count, used for the Hamming distance of a step
package gray_pkg;

   localparam int DEF_WIDTH         = 10;
   localparam int DEF_STABLE_CYCLES = 4;
   localparam int ERR_CNT_W         = 8;
   localparam int POS_W             = 16;
   localparam int RUN_W             = 4;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_TRACKING = 1'b1
   } gray_state_e;

   // Callers zero-extend their vector to 32 bits; codes wider than 32 bits
   // are not supported by this helper.
   function automatic logic [5:0] popcount(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) begin
         c = c + 6'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/gray_decoder.sv
// gray_decoder: combinational Gray-to-binary conversion.
//   Each binary bit is the XOR of all Gray bits at and above its position
//   (prefix XOR from the MSB down).
// Ports:
//   gray_i [WIDTH-1:0] in  : Gray-coded value
//   bin_o  [WIDTH-1:0] out : binary equivalent
module gray_decoder #(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   always_comb begin
      bin_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin_o[i] = ^(gray_i >> i);
      end
   end

endmodule

// File: rtl/gray_tracker.sv
// gray_tracker: synchronizes an asynchronous Gray-coded bus, filters it for
// stability, and tracks accepted codes: binary value, step direction,
// illegal-step detection/count and (optionally) a signed position.
//
// Optional feature: define GRAY_TRACKER_POS_EN to build the position
// accumulator; otherwise pos is tied to zero.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   gray_in   in   asynchronous Gray-coded bus [WIDTH-1:0]
//   clr       in   synchronous clear of lock, error count and position
//   bin       out  binary value of the last accepted code [WIDTH-1:0]
//   valid     out  one-cycle pulse when a new code is accepted
//   dir       out  direction of last legal step (1 = up, 0 = down)
//   step_err  out  one-cycle pulse with valid on an illegal step
//   err_cnt   out  saturating illegal-step count [7:0]
//   locked    out  high once a first code has been accepted
//   pos       out  signed position accumulator [15:0]
//   dbg_state out  current FSM state
//
// Handshake: valid is a pure output strobe (no ready); bin/dir/step_err are
// meaningful in the cycle valid is high and bin/dir hold afterwards.
module gray_tracker
   import gray_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [WIDTH-1:0]        gray_in,
   input  logic                    clr,
   output logic [WIDTH-1:0]        bin,
   output logic                    valid,
   output logic                    dir,
   output logic                    step_err,
   output logic [ERR_CNT_W-1:0]    err_cnt,
   output logic                    locked,
   output logic signed [POS_W-1:0] pos,
   output gray_state_e             dbg_state
);

   localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(STABLE_CYCLES);
   localparam logic [RUN_W-1:0] RUN_ACC = RUN_W'(STABLE_CYCLES - 1);

   // synchronizer and stability filter
   logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
   logic [1:0]       sync_vld_q, sync_vld_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic             cand_vld_q, cand_vld_d;
   logic [RUN_W-1:0] run_q, run_d;

   // tracking state
   gray_state_e          state_q, state_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]     bin_q, bin_d;
   logic                 dir_q, dir_d;
   logic                 valid_q, valid_d;
   logic                 step_err_q, step_err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [WIDTH-1:0] cand_bin;
   logic [5:0]       hd;
   logic             is_legal;
   logic             is_up;
   logic             accept;

   gray_decoder #(.WIDTH(WIDTH)) u_dec (
      .gray_i (cand_q),
      .bin_o  (cand_bin)
   );

   // sync_vld marks s2 as holding a real sample rather than its reset value,
   // so that the first candidate after reset is loaded from live data and
   // needs the full STABLE_CYCLES run.
   always_comb begin
      s1_d       = gray_in;
      s2_d       = s1_q;
      sync_vld_d = {sync_vld_q[0], 1'b1};
      cand_d     = cand_q;
      cand_vld_d = cand_vld_q;
      run_d      = run_q;
      if (sync_vld_q[1]) begin
         if (!cand_vld_q || (s2_q != cand_q)) begin
            cand_d     = s2_q;
            cand_vld_d = 1'b1;
            run_d      = '0;
         end else if (run_q < RUN_SAT) begin
            run_d = run_q + RUN_W'(1);
         end
      end
   end

   // Fires exactly once per candidate: the run passes RUN_ACC only once.
   assign accept = cand_vld_q && (s2_q == cand_q) && (run_q == RUN_ACC) &&
                   ((cand_q != acc_q) || (state_q == ST_UNLOCKED));

   assign hd       = popcount(32'(cand_q ^ acc_q));
   assign is_legal = (hd == 6'd1);
   assign is_up    = (cand_bin == (bin_q + WIDTH'(1)));

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      bin_d      = bin_q;
      dir_d      = dir_q;
      valid_d    = 1'b0;
      step_err_d = 1'b0;
      err_cnt_d  = err_cnt_q;
      if (clr) begin
         // a coincident accept is dropped; bin and dir keep their values
         state_d   = ST_UNLOCKED;
         err_cnt_d = '0;
      end else if (accept) begin
         valid_d = 1'b1;
         acc_d   = cand_q;
         bin_d   = cand_bin;
         state_d = ST_TRACKING;
         if (state_q == ST_TRACKING) begin
            if (is_legal) begin
               dir_d = is_up;
            end else begin
               // bin still follows the new code to resynchronize
               step_err_d = 1'b1;
               if (err_cnt_q != '1) begin
                  err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= '0;
         s2_q       <= '0;
         sync_vld_q <= '0;
         cand_q     <= '0;
         cand_vld_q <= 1'b0;
         run_q      <= '0;
         state_q    <= ST_UNLOCKED;
         acc_q      <= '0;
         bin_q      <= '0;
         dir_q      <= 1'b1;
         valid_q    <= 1'b0;
         step_err_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         sync_vld_q <= sync_vld_d;
         cand_q     <= cand_d;
         cand_vld_q <= cand_vld_d;
         run_q      <= run_d;
         state_q    <= state_d;
         acc_q      <= acc_d;
         bin_q      <= bin_d;
         dir_q      <= dir_d;
         valid_q    <= valid_d;
         step_err_q <= step_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

`ifdef GRAY_TRACKER_POS_EN
   logic [POS_W-1:0] pos_q, pos_d;
   logic             track_step;

   // only legal steps taken while already tracking move the position
   assign track_step = accept && !clr && (state_q == ST_TRACKING);

   always_comb begin
      pos_d = pos_q;
      if (clr) begin
         pos_d = '0;
      end else if (track_step && is_legal) begin
         pos_d = is_up ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q <= '0;
      end else begin
         pos_q <= pos_d;
      end
   end

   assign pos = pos_q;
`else
   assign pos = '0;
`endif

   assign bin       = bin_q;
   assign valid     = valid_q;
   assign dir       = dir_q;
   assign step_err  = step_err_q;
   assign err_cnt   = err_cnt_q;
   assign locked    = (state_q == ST_TRACKING);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_gray_tracker.sv
// tb_gray_tracker: directed test of gray_tracker (WIDTH=10, STABLE_CYCLES=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_gray_tracker;
  import gray_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [9:0]        gray_in;
  logic              clr;
  logic [9:0]        bin;
  logic              valid;
  logic              dir;
  logic              step_err;
  logic [7:0]        err_cnt;
  logic              locked;
  logic signed [15:0] pos;
  gray_state_e       dbg_state;

  int tests;
  int fails;
  int vld_cnt;
  int serr_cnt;
  logic [9:0] last_bin;
  logic       last_dir;
  logic       last_err;
  logic [15:0] exp_pos;

  gray_tracker #(.WIDTH(10), .STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .clr       (clr),
    .bin       (bin),
    .valid     (valid),
    .dir       (dir),
    .step_err  (step_err),
    .err_cnt   (err_cnt),
    .locked    (locked),
    .pos       (pos),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive a code and observe n falling edges, recording any valid pulse
  task automatic hold(input logic [9:0] g, input int n);
    gray_in = g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (valid) begin
        vld_cnt++;
        last_bin = bin;
        last_dir = dir;
        last_err = step_err;
      end
      if (step_err) serr_cnt++;
    end
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; vld_cnt = 0; serr_cnt = 0;
    last_bin = '0; last_dir = 1'b0; last_err = 1'b0;
    rst_n = 1'b0; gray_in = '0; clr = 1'b0;
`ifdef GRAY_TRACKER_POS_EN
    exp_pos = 16'd2;
`else
    exp_pos = 16'd0;
`endif

    // reset state
    repeat (3) @(negedge clk);
    check("rst_bin", 32'(bin), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_dir", 32'(dir), 1);
    check("rst_step_err", 32'(step_err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_pos", 32'(pos), 0);

    // first accept after release: VALID on the 7th rising edge
    rst_n = 1'b1;
    hold(10'h000, 6);
    check("first_no_early_valid", 32'(vld_cnt), 0);
    hold(10'h000, 1);
    check("first_valid", 32'(valid), 1);
    check("first_bin", 32'(bin), 0);
    check("first_locked", 32'(locked), 1);
    check("first_step_err", 32'(step_err), 0);
    hold(10'h000, 1);
    check("first_valid_pulse", 32'(valid), 0);

    // binary 5 -> 6 -> 7 : Gray 111 -> 101 -> 100
    clr_pulse();
    vld_cnt = 0; serr_cnt = 0;
    hold(10'h007, 10);
    check("b5_bin", 32'(last_bin), 5);
    hold(10'h005, 10);
    check("b6_bin", 32'(last_bin), 6);
    check("b6_dir", 32'(last_dir), 1);
    hold(10'h004, 10);
    check("b7_bin", 32'(last_bin), 7);
    check("b7_dir", 32'(last_dir), 1);
    check("seq_valids", 32'(vld_cnt), 3);
    check("seq_err_cnt", 32'(err_cnt), 0);
    check("seq_step_errs", 32'(serr_cnt), 0);
    check("seq_pos", 32'(16'(pos)), 32'(exp_pos));

    // glitching between Gray 1100 and 100 every 2 cycles: no accept
    vld_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      hold(10'h00C, 2);
      hold(10'h004, 2);
    end
    check("glitch_no_valid", 32'(vld_cnt), 0);
    hold(10'h00C, 10);
    check("glitch_then_stable_valid", 32'(vld_cnt), 1);
    check("glitch_then_stable_bin", 32'(last_bin), 8);

    // wrap steps: 1023 (Gray 1000000000) <-> 0
    clr_pulse();
    vld_cnt = 0; serr_cnt = 0;
    hold(10'h200, 10);
    check("wrap_unlocked_bin", 32'(last_bin), 1023);
    hold(10'h000, 10);
    check("wrap_up_bin", 32'(last_bin), 0);
    check("wrap_up_dir", 32'(last_dir), 1);
    hold(10'h200, 10);
    check("wrap_down_bin", 32'(last_bin), 1023);
    check("wrap_down_dir", 32'(last_dir), 0);
    check("wrap_step_errs", 32'(serr_cnt), 0);
    // 1023 -> 0 up, 0 -> 1 up, 1 -> 0 down: dir ends at 0
    hold(10'h000, 10);
    hold(10'h001, 10);
    hold(10'h000, 10);
    check("down_to_zero_dir", 32'(dir), 0);
    check("walk_valids", 32'(vld_cnt), 6);
`ifdef GRAY_TRACKER_POS_EN
    // +1 -1 +1 +1 -1 since the clear
    check("walk_pos", 32'(16'(pos)), 1);
`else
    check("walk_pos", 32'(16'(pos)), 0);
`endif

    // illegal jump: binary 0 -> 2 (Gray 000 -> 011, two bits change)
    serr_cnt = 0;
    hold(10'h003, 10);
    check("jump_step_err", 32'(last_err), 1);
    check("jump_bin", 32'(last_bin), 2);
    check("jump_err_cnt", 32'(err_cnt), 1);
    check("jump_dir_held", 32'(dir), 0);

    // repeated illegal jumps between Gray 011 and 1100 saturate the count
    for (int k = 0; k < 253; k++) begin
      hold(((k % 2) == 0) ? 10'h00C : 10'h003, 8);
    end
    check("err_cnt_254", 32'(err_cnt), 254);
    for (int k = 253; k < 300; k++) begin
      hold(((k % 2) == 0) ? 10'h00C : 10'h003, 8);
    end
    check("err_cnt_sat", 32'(err_cnt), 255);
    check("jump_pulses", 32'(serr_cnt), 301);

    // clr coinciding with the accept edge
    gray_in = 10'h100;
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_valid", 32'(valid), 0);
    check("clr_locked", 32'(locked), 0);
    check("clr_err_cnt", 32'(err_cnt), 0);
    check("clr_bin_held", 32'(bin), 2);
    check("clr_pos", 32'(16'(pos)), 0);
    vld_cnt = 0; serr_cnt = 0;
    hold(10'h100, 10);
    check("clr_discarded", 32'(vld_cnt), 0);
    // Gray 1111111111 -> binary 1010101010 = 682; far jump, but unlocked
    hold(10'h3FF, 10);
    check("post_clr_valid", 32'(vld_cnt), 1);
    check("post_clr_bin", 32'(last_bin), 682);
    check("post_clr_no_step_err", 32'(serr_cnt), 0);
    check("post_clr_locked", 32'(locked), 1);

    // reset in the middle of filtering a new candidate
    hold(10'h001, 4);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_bin", 32'(bin), 0);
    check("midrst_dir", 32'(dir), 1);
    check("midrst_locked", 32'(locked), 0);
    rst_n = 1'b1;
    vld_cnt = 0;
    hold(10'h001, 6);
    check("midrst_no_early_valid", 32'(vld_cnt), 0);
    hold(10'h001, 1);
    check("midrst_valid", 32'(valid), 1);
    check("midrst_new_bin", 32'(bin), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
